gaussian_hline_filter: RTL and testbench
========================================

// Module: gaussian_hline_filter
// PURPOSE
// - Pipelined Gaussian core of the VAI Gaussian AFU. Sits between the registered c0 read-response path
//   (sRx.c0.data/rspValid) and the c1 write-request staging logic.
// - Applies a 3-tap [1 2 1]/4 horizontal blur to every pixel of one 512-bit cache line per cycle.
// - Carries the line's 16-bit mdata tag alongside the data, so the write stage can derive the destination
//   address even when responses arrive out of order.
// PARAMETERS
// - PIXEL_W   8    bits per pixel; must divide 512 (NUM_PIX = 512/PIXEL_W, 64 by default)
// - TAG_W     16   width of the mdata sideband tag
// PORTS
// - clk        in   1        AFU clock
// - reset      in   1        synchronous, active-high reset
// - valid_in   in   1        line valid (c0 RDLINE response, cl_len 1)
// - data_in    in   512      input cache line; pixel i = data_in[i*PIXEL_W +: PIXEL_W]
// - tag_in     in   TAG_W    mdata of the line
// - bypass     in   1        1 = pass the line through unfiltered; sampled with valid_in
// - clear_cnt  in   1        synchronous clear of line_cnt
// - valid_out  out  1        filtered line valid
// - data_out   out  512      filtered cache line
// - tag_out    out  TAG_W    tag_in of the same line
// - line_cnt   out  32       lines emitted since reset/clear; saturating
// BEHAVIOUR
// - Reset values: valid_out=0, data_out=0, tag_out=0, line_cnt=0. All pipeline valid bits are cleared.
// - Throughput and latency:
//   - Accepts one line every cycle; there is no stall and no backpressure.
//   - Fixed latency of 3: a line with valid_in at cycle T appears with valid_out at T+3.
//   - Output order equals input order.
// - Pipeline:
//   - S1: register data, tag, bypass and valid.
//   - S2: compute per pixel a_i = p[i-1] + p[i+1] (PIXEL_W+1 bits) and b_i = p[i] << 1.
//   - S3: out_i = (a_i + b_i + 2) >> 2, computed at PIXEL_W+2 bits.
// - Width rule: the maximum is (4*(2^PIXEL_W-1)+2) >> 2 = 2^PIXEL_W-1, so no saturation is needed.
// - Edges replicate: p[-1] = p[0] and p[NUM_PIX] = p[NUM_PIX-1]. Pixels never cross line boundaries.
// - bypass=1: data_out equals the registered data_in, with the same 3-cycle latency and the same
//   valid/tag timing. Bypass and filtered lines may interleave on consecutive cycles.
// - Invalid stages: data and tag registers may hold stale values, but data_out/tag_out update only when
//   the S3 valid bit is set; otherwise they hold.
// - line_cnt:
//   - Increments on each valid_out and saturates at 32'hFFFF_FFFF.
//   - clear_cnt alone: next value is 0.
//   - clear_cnt together with valid_out: next value is 1.
// - Reset mid-operation: in-flight lines are dropped, so there is no valid_out for lines accepted before
//   reset. A line presented in the first cycle after reset deasserts is processed normally.
// - valid_in during reset: ignored.
// STRUCTURE
// - Package gaussian_pkg:
//   - localparams PIXEL_W and NUM_PIX.
//   - typedefs t_pixel (logic [PIXEL_W-1:0]), t_line (t_pixel [NUM_PIX-1:0]) and t_tag.
//   - function gauss3(l, c, r) returning the rounded t_pixel.
// - One sub-module, gaussian_pix_tap: the S2/S3 arithmetic for a single pixel, instantiated NUM_PIX times
//   in a generate loop. The top level owns the S1 registers, edge replication, the valid/tag/bypass
//   pipeline and line_cnt.
// TESTING
// - Constant line, all pixels 8'h80, tag 16'h0005 at T -> at T+3: all pixels 8'h80, tag 16'h0005,
//   line_cnt=1.
// - Ramp p[i]=4*i -> out[0]=8'd1, out[1]=8'd4, out[32]=8'd128, out[63]=8'd251. Impulse p[10]=8'hFF,
//   others 0 -> out[9]=64, out[10]=128, out[11]=64, all other pixels 0.
// - All pixels 8'hFF -> all 8'hFF (checks the rounding width). All zero -> all zero.
// - 4 back-to-back lines with tags 16'h7FFE, 16'h7FFF, 16'h8000, 16'h0000 and bypass alternating 0/1 ->
//   4 consecutive valid_out cycles, same tag order, bypass lines bit-exact to their inputs.
// - Reset asserted 1 cycle after 2 lines enter -> no valid_out for those lines; line_cnt=0. A new line
//   after reset appears 3 cycles later.
// - Preload line_cnt to 32'hFFFF_FFFE, send 3 lines -> line_cnt=32'hFFFF_FFFF. Then clear_cnt coincident
//   with valid_out -> line_cnt=1; clear_cnt alone -> 0.

Source files
------------

// File: rtl/gaussian_pkg.sv
// Shared pixel/line types and the scalar reference for the 3-tap [1 2 1]/4 blur.
package gaussian_pkg;
  localparam int PIXEL_W = 8;
  localparam int NUM_PIX = 512 / PIXEL_W;
  localparam int TAG_W   = 16;

  typedef logic [PIXEL_W-1:0]  t_pixel;
  typedef t_pixel [NUM_PIX-1:0] t_line;
  typedef logic [TAG_W-1:0]    t_tag;

  // Two guard bits hold l + 2c + r + 2 without overflow, so no saturation is needed.
  function automatic t_pixel gauss3(t_pixel l, t_pixel c, t_pixel r);
    logic [PIXEL_W+1:0] s;
    s = {2'b00, l} + {2'b00, r} + {1'b0, c, 1'b0} + (PIXEL_W+2)'(2);
    return s[PIXEL_W+1:2];
  endfunction
endpackage

// File: rtl/gaussian_pix_tap.sv
// One pixel of the blur: S2 registers the neighbour sum and doubled centre,
// S3 adds them with rounding (combinational here, registered by the top).
module gaussian_pix_tap #(
  parameter int PIXEL_W = gaussian_pkg::PIXEL_W
) (
  input  logic               clk,
  input  logic [PIXEL_W-1:0] l_i,
  input  logic [PIXEL_W-1:0] c_i,
  input  logic [PIXEL_W-1:0] r_i,
  output logic [PIXEL_W-1:0] pix_o
);
  logic [PIXEL_W:0]   a_q, b_q;
  logic [PIXEL_W+1:0] sum;

  always_ff @(posedge clk) begin
    a_q <= {1'b0, l_i} + {1'b0, r_i};
    b_q <= {c_i, 1'b0};
  end

  assign sum   = {1'b0, a_q} + {1'b0, b_q} + (PIXEL_W+2)'(2);
  assign pix_o = sum[PIXEL_W+1:2];
endmodule

// File: rtl/gaussian_hline_filter.sv
// 3-stage horizontal [1 2 1]/4 blur over one 512-bit line per cycle, with
// per-line bypass, tag sideband and a saturating emitted-line counter.
module gaussian_hline_filter #(
  parameter int PIXEL_W = gaussian_pkg::PIXEL_W,
  parameter int TAG_W   = gaussian_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [511:0]     data_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             bypass,
  input  logic             clear_cnt,
  output logic             valid_out,
  output logic [511:0]     data_out,
  output logic [TAG_W-1:0] tag_out,
  output logic [31:0]      line_cnt
);
  localparam int NUM_PIX = 512 / PIXEL_W;

  logic [3:1]                       vld_pipe_q;
  logic [511:0]                     data1_q, data2_q, data_out_q;
  logic [TAG_W-1:0]                 tag1_q, tag2_q, tag_out_q;
  logic                             byp1_q, byp2_q;
  logic [NUM_PIX-1:0][PIXEL_W-1:0]  pix1, filt;
  logic [31:0]                      line_cnt_q, line_cnt_d;

  assign pix1 = data1_q;

  // Edges replicate the outermost pixel so nothing leaks across lines.
  for (genvar i = 0; i < NUM_PIX; i++) begin : g_tap
    localparam int LI = (i == 0) ? 0 : i - 1;
    localparam int RI = (i == NUM_PIX - 1) ? NUM_PIX - 1 : i + 1;
    gaussian_pix_tap #(.PIXEL_W(PIXEL_W)) u_tap (
      .clk   (clk),
      .l_i   (pix1[LI]),
      .c_i   (pix1[i]),
      .r_i   (pix1[RI]),
      .pix_o (filt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) vld_pipe_q <= '0;
    else       vld_pipe_q <= {vld_pipe_q[2:1], valid_in};
  end

  always_ff @(posedge clk) begin
    data1_q <= data_in;
    tag1_q  <= tag_in;
    byp1_q  <= bypass;
    data2_q <= data1_q;
    tag2_q  <= tag1_q;
    byp2_q  <= byp1_q;
  end

  always_comb begin
    line_cnt_d = line_cnt_q;
    if (clear_cnt)                               line_cnt_d = vld_pipe_q[2] ? 32'd1 : 32'd0;
    else if (vld_pipe_q[2] && (~&line_cnt_q))    line_cnt_d = line_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
      tag_out_q  <= '0;
      line_cnt_q <= '0;
    end else begin
      if (vld_pipe_q[2]) begin
        data_out_q <= byp2_q ? data2_q : filt;
        tag_out_q  <= tag2_q;
      end
      line_cnt_q <= line_cnt_d;
    end
  end

  assign valid_out = vld_pipe_q[3];
  assign data_out  = data_out_q;
  assign tag_out   = tag_out_q;
  assign line_cnt  = line_cnt_q;
endmodule

// File: tb/tb_gaussian_hline_filter.sv
// Randomised and directed bench for gaussian_hline_filter against a line-level scoreboard model.
module tb_gaussian_hline_filter;
  logic         clk = 1'b0;
  logic         reset = 1'b1, valid_in = 1'b0, bypass = 1'b0, clear_cnt = 1'b0;
  logic [511:0] data_in = '0;
  logic [15:0]  tag_in = '0;
  logic         valid_out;
  logic [511:0] data_out;
  logic [15:0]  tag_out;
  logic [31:0]  line_cnt;

  gaussian_hline_filter dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .tag_in(tag_in),
    .bypass(bypass), .clear_cnt(clear_cnt), .valid_out(valid_out), .data_out(data_out),
    .tag_out(tag_out), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [511:0] d; logic [15:0] tag; int due; } exp_t;
  exp_t         sb[$];
  int           n_chk = 0, n_fail = 0, cyc = 0;
  logic [511:0] last_d = '0;
  logic [15:0]  last_tag = '0;
  logic [31:0]  cnt_m = '0;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [511:0] ref_line(input logic [511:0] d, input logic byp);
    logic [511:0] r;
    int l, c, rr;
    if (byp) return d;
    for (int i = 0; i < 64; i++) begin
      l  = int'(d[((i == 0) ? 0 : i - 1) * 8 +: 8]);
      c  = int'(d[i * 8 +: 8]);
      rr = int'(d[((i == 63) ? 63 : i + 1) * 8 +: 8]);
      r[i * 8 +: 8] = 8'((l + 2 * c + rr + 2) / 4);
    end
    return r;
  endfunction

  function automatic logic [511:0] rnd_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i * 32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] pix(input logic [511:0] d, input int i);
    return d[i * 8 +: 8];
  endfunction

  task automatic step(input logic v, input logic [511:0] d, input logic [15:0] t,
                      input logic b, input logic clr, input logic rst);
    bit out_now;
    valid_in = v; data_in = d; tag_in = t; bypass = b; clear_cnt = clr; reset = rst;
    out_now = (sb.size() > 0) && (sb[0].due == cyc + 1);
    if (rst) begin
      sb.delete(); cnt_m = '0; last_d = '0; last_tag = '0;
    end else begin
      if (v) sb.push_back('{ref_line(d, b), t, cyc + 3});
      if (clr)                                     cnt_m = out_now ? 32'd1 : 32'd0;
      else if (out_now && cnt_m != 32'hFFFF_FFFF)  cnt_m = cnt_m + 32'd1;
    end
    @(posedge clk); @(negedge clk);
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("valid_out", 512'(valid_out), 512'd1);
      last_d = sb[0].d; last_tag = sb[0].tag;
      void'(sb.pop_front());
    end else begin
      chk("valid_out", 512'(valid_out), 512'd0);
    end
    chk("data_out", data_out, last_d);
    chk("tag_out", 512'(tag_out), 512'(last_tag));
    chk("line_cnt", 512'(line_cnt), 512'(cnt_m));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [511:0] ln;
    logic [15:0]  tags [4];
    tags[0] = 16'h7FFE; tags[1] = 16'h7FFF; tags[2] = 16'h8000; tags[3] = 16'h0000;

    // reset state (valid_in high during reset must be ignored)
    step(1'b1, rnd_line(), 16'h1234, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 512'(valid_out), 512'd0);
    chk("rst_data", data_out, 512'd0);
    chk("rst_tag", 512'(tag_out), 512'd0);
    chk("rst_cnt", 512'(line_cnt), 512'd0);
    idle(3);

    // constant line
    step(1'b1, {64{8'h80}}, 16'h0005, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("const_vo", 512'(valid_out), 512'd1);
    chk("const_data", data_out, {64{8'h80}});
    chk("const_tag", 512'(tag_out), 512'h5);
    chk("const_cnt", 512'(line_cnt), 512'd1);
    idle(1);

    // ramp
    for (int i = 0; i < 64; i++) ln[i * 8 +: 8] = 8'(4 * i);
    step(1'b1, ln, 16'h0011, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("ramp_p0", 512'(pix(data_out, 0)), 512'd1);
    chk("ramp_p1", 512'(pix(data_out, 1)), 512'd4);
    chk("ramp_p32", 512'(pix(data_out, 32)), 512'd128);
    chk("ramp_p63", 512'(pix(data_out, 63)), 512'd251);

    // impulse
    ln = '0; ln[80 +: 8] = 8'hFF;
    step(1'b1, ln, 16'h0012, 1'b0, 1'b0, 1'b0);
    idle(3);
    ln = '0; ln[72 +: 8] = 8'd64; ln[80 +: 8] = 8'd128; ln[88 +: 8] = 8'd64;
    chk("impulse", data_out, ln);

    // full scale then zero, back to back
    step(1'b1, {64{8'hFF}}, 16'h0013, 1'b0, 1'b0, 1'b0);
    step(1'b1, '0, 16'h0014, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("allFF", data_out, {64{8'hFF}});
    idle(1);
    chk("all0", data_out, 512'd0);
    idle(1);

    // tag wrap with alternating bypass
    for (int k = 0; k < 4; k++) step(1'b1, rnd_line(), tags[k], 1'(k % 2), 1'b0, 1'b0);
    idle(3);

    // reset one cycle after two lines enter
    step(1'b1, rnd_line(), 16'h0A01, 1'b0, 1'b0, 1'b0);
    step(1'b1, rnd_line(), 16'h0A02, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("midrst_cnt", 512'(line_cnt), 512'd0);
    step(1'b1, rnd_line(), 16'h0A03, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("postrst_vo", 512'(valid_out), 512'd1);
    chk("postrst_tag", 512'(tag_out), 512'h0A03);
    idle(1);

    // counter saturation and clear
    force dut.line_cnt_q = 32'hFFFF_FFFE;
    cnt_m = 32'hFFFF_FFFE;
    idle(1);
    release dut.line_cnt_q;
    for (int k = 0; k < 3; k++) step(1'b1, rnd_line(), 16'(k), 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("sat_cnt", 512'(line_cnt), 512'hFFFF_FFFF);
    step(1'b1, rnd_line(), 16'h0B00, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("clr_with_vo", 512'(line_cnt), 512'd1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("clr_alone", 512'(line_cnt), 512'd0);

    // randomised traffic
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 3) != 0), rnd_line(), 16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
